// File: rtl/imgproc_pkg.sv
// Shared constants and state encoding for the imgproc frame sequencer.
package imgproc_pkg;

  localparam int unsigned IMG_W_DEF = 128;
  localparam int unsigned IMG_H_DEF = 128;
  localparam int unsigned N_PIX     = IMG_W_DEF * IMG_H_DEF;
  localparam int unsigned PIX_AW    = 14;
  localparam int unsigned PIX_DW    = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StRun   = S_RUN,
    StDrain = S_DRAIN,
    StDone  = S_DONE
  } state_e;

endpackage

// File: rtl/imgproc_raster_cnt.sv
// Returned-pixel counter that also provides the raster tags (col, row, last) of the
// pixel currently at the head of the count.
module imgproc_raster_cnt
  import imgproc_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned NPIX  = N_PIX,
  parameter int unsigned CW    = PIX_AW + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [6:0] col,
  output logic [6:0] row,
  output logic       last
);

  localparam logic [CW-1:0] N_C = CW'(NPIX);
  localparam logic [CW-1:0] W_C = CW'(IMG_W);

  logic [CW-1:0] cnt_q;

  // Stops at NPIX so a frame never wraps back onto pixel 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (step && (cnt_q != N_C)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign col  = 7'(cnt_q % W_C);
  assign row  = 7'(cnt_q / W_C);
  assign last = (cnt_q == (N_C - CW'(1)));

endmodule

// File: rtl/imgproc_seq.sv
// Frame sequencer: raster-order source reads under a credit limit, tagged forwarding of
// returned pixels to the datapath, in-order writeback of results and frame completion.
module imgproc_seq
  import imgproc_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned AW      = PIX_AW,
  parameter int unsigned DW      = PIX_DW,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          request,
  output logic [AW-1:0] orig_addr,
  input  logic          orig_ready,
  input  logic [DW-1:0] orig_data,
  output logic          dp_valid,
  output logic [DW-1:0] dp_data,
  output logic [6:0]    dp_col,
  output logic [6:0]    dp_row,
  output logic          dp_last,
  input  logic          dp_res_valid,
  input  logic [DW-1:0] dp_res_data,
  output logic          imgproc_ready,
  output logic [AW-1:0] imgproc_addr,
  output logic [DW-1:0] imgproc_data,
  output logic          finish,
  output logic          protocol_err
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [3:0]    MAX_C  = 4'(MAX_OUT);

  state_e        state_q;
  logic [CW-1:0] rd_cnt_q;
  logic [CW-1:0] wr_cnt_q;
  logic [3:0]    out_cnt_q;

  logic       issue;
  logic       ret_ok;
  logic       spurious;
  logic       wr_ok;
  logic [6:0] tag_col;
  logic [6:0] tag_row;
  logic       tag_last;

  // out_cnt already counts the read whose strobe is visible this cycle, so a return is only
  // legal when at least one credit is in use.
  always_comb begin
    ret_ok   = orig_ready && (out_cnt_q != 4'd0);
    spurious = orig_ready && (out_cnt_q == 4'd0);
    issue    = (state_q == StRun) && (rd_cnt_q != N_C) && ((out_cnt_q < MAX_C) || ret_ok);
    wr_ok    = dp_res_valid && (wr_cnt_q != N_C);
  end

  imgproc_raster_cnt #(
    .IMG_W (IMG_W),
    .NPIX  (N),
    .CW    (CW)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .step (ret_ok),
    .col  (tag_col),
    .row  (tag_row),
    .last (tag_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      out_cnt_q     <= '0;
      request       <= 1'b0;
      orig_addr     <= '0;
      dp_valid      <= 1'b0;
      dp_data       <= '0;
      dp_col        <= '0;
      dp_row        <= '0;
      dp_last       <= 1'b0;
      imgproc_ready <= 1'b0;
      imgproc_addr  <= '0;
      imgproc_data  <= '0;
      finish        <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StRun;
        StRun:   if (issue && (rd_cnt_q == LAST_C)) state_q <= StDrain;
        StDrain: begin
          if (wr_ok && (wr_cnt_q == LAST_C)) begin
            state_q <= StDone;
            finish  <= 1'b1;
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase

      request <= issue;
      if (issue) begin
        orig_addr <= rd_cnt_q[AW-1:0];
        rd_cnt_q  <= rd_cnt_q + CW'(1);
      end

      case ({issue, ret_ok})
        2'b10:   out_cnt_q <= out_cnt_q + 4'd1;
        2'b01:   out_cnt_q <= out_cnt_q - 4'd1;
        default: out_cnt_q <= out_cnt_q;
      endcase

      if (spurious) protocol_err <= 1'b1;

      dp_valid <= ret_ok;
      if (ret_ok) begin
        dp_data <= orig_data;
        dp_col  <= tag_col;
        dp_row  <= tag_row;
        dp_last <= tag_last;
      end

      imgproc_ready <= wr_ok;
      if (wr_ok) begin
        imgproc_addr <= wr_cnt_q[AW-1:0];
        imgproc_data <= dp_res_data;
        wr_cnt_q     <= wr_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imgproc_seq.sv
// Scoreboard bench for imgproc_seq: memory and identity-datapath models push expectations,
// a monitor pops and compares every DUT output transaction.
module tb_imgproc_seq;
  import imgproc_pkg::*;

  localparam int N    = N_PIX;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        request;
  logic [13:0] orig_addr;
  logic        orig_ready = 1'b0;
  logic [7:0]  orig_data = 8'h00;
  logic        dp_valid;
  logic [7:0]  dp_data;
  logic [6:0]  dp_col;
  logic [6:0]  dp_row;
  logic        dp_last;
  logic        dp_res_valid = 1'b0;
  logic [7:0]  dp_res_data = 8'h00;
  logic        imgproc_ready;
  logic [13:0] imgproc_addr;
  logic [7:0]  imgproc_data;
  logic        finish;
  logic        protocol_err;

  imgproc_seq #(
    .MAX_OUT (MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .orig_addr     (orig_addr),
    .orig_ready    (orig_ready),
    .orig_data     (orig_data),
    .dp_valid      (dp_valid),
    .dp_data       (dp_data),
    .dp_col        (dp_col),
    .dp_row        (dp_row),
    .dp_last       (dp_last),
    .dp_res_valid  (dp_res_valid),
    .dp_res_data   (dp_res_data),
    .imgproc_ready (imgproc_ready),
    .imgproc_addr  (imgproc_addr),
    .imgproc_data  (imgproc_data),
    .finish        (finish),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0] d;
    logic [6:0] c;
    logic [6:0] r;
    logic       l;
  } dp_exp_t;
  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_exp_t;
  typedef struct packed {
    int          cy;
    logic [13:0] a;
  } rd_t;

  dp_exp_t dp_q[$];
  wr_exp_t wr_q[$];
  rd_t     mem_q[$];

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int reqs, rets, wr_idx, t3_events;
  int exp_addr, dp_seen, wr_seen;
  logic pend_v, t3_flag;
  logic [7:0] pend_d;
  logic spur_req = 1'b0;
  logic extra_req = 1'b0;

  function automatic logic [7:0] pix(input int a);
    logic [31:0] v;
    v = a * 37 + (a >> 7) * 11;
    return v[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model with fixed latency plus an identity datapath of latency 1.
  always @(negedge clk) begin
    rd_t r;
    int  k;
    if (!rst) begin
      mem_q.delete(); dp_q.delete(); wr_q.delete();
      reqs = 0; rets = 0; wr_idx = 0; t3_events = 0;
      pend_v = 1'b0; pend_d = 8'h00; t3_flag = 1'b0;
      orig_ready = 1'b0; orig_data = 8'h00;
      dp_res_valid = 1'b0; dp_res_data = 8'h00;
    end else begin
      if (request) begin
        mem_q.push_back('{cy: cyc, a: orig_addr});
        reqs++;
        chk("outstanding_le_max", 64'((reqs - rets) <= MAXO), 64'd1);
      end
      if (t3_flag) begin
        chk("issue_on_return_at_max", request, 1'b1);
        t3_flag = 1'b0;
      end
      orig_ready = 1'b0;
      orig_data  = 8'h00;
      if (spur_req) begin
        orig_ready = 1'b1;
        orig_data  = 8'hAA;
        spur_req   = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].cy + lat <= cyc) begin
        r = mem_q.pop_front();
        if ((reqs - rets) == MAXO && reqs < N) begin
          t3_flag = 1'b1;
          t3_events++;
        end
        orig_ready = 1'b1;
        orig_data  = pix(int'(r.a));
        k = rets;
        dp_q.push_back('{d: pix(k), c: 7'(k % 128), r: 7'(k / 128), l: (k == N - 1)});
        rets++;
      end
      dp_res_valid = 1'b0;
      dp_res_data  = 8'h00;
      if (pend_v) begin
        dp_res_valid = 1'b1;
        dp_res_data  = pend_d;
        if (wr_idx < N) begin
          wr_q.push_back('{a: 14'(wr_idx), d: pix(wr_idx)});
          wr_idx++;
        end
      end else if (extra_req) begin
        dp_res_valid = 1'b1;
        dp_res_data  = 8'h33;
        extra_req    = 1'b0;
      end
      pend_v = dp_valid;
      pend_d = dp_data;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  always @(posedge clk) begin
    dp_exp_t e;
    wr_exp_t w;
    #1;
    if (!rst) begin
      exp_addr = 0; dp_seen = 0; wr_seen = 0;
    end else begin
      if (request) begin
        chk("rd_addr", orig_addr, 64'(exp_addr));
        exp_addr++;
      end
      if (dp_valid) begin
        if (dp_q.size() == 0) begin
          chk("dp_unexpected", dp_valid, 1'b0);
        end else begin
          e = dp_q.pop_front();
          chk("dp_data_tags", {dp_data, dp_col, dp_row, dp_last}, e);
          if (dp_seen == 127) chk("tag_px127", {dp_col, dp_row, dp_last}, {7'd127, 7'd0, 1'b0});
          if (dp_seen == 128) chk("tag_px128", {dp_col, dp_row, dp_last}, {7'd0, 7'd1, 1'b0});
          if (dp_seen == N - 1)
            chk("tag_px16383", {dp_col, dp_row, dp_last}, {7'd127, 7'd127, 1'b1});
          dp_seen++;
        end
      end
      if (imgproc_ready) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", imgproc_ready, 1'b0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr_data", {imgproc_addr, imgproc_data}, w);
          wr_seen++;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {request, orig_addr, dp_valid, dp_data, dp_col, dp_row, dp_last, imgproc_ready,
             imgproc_addr, imgproc_data, finish, protocol_err}, 64'd0);
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("rst_outputs_zero");
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset(output int t0);
    @(posedge clk);
    #2 rst = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_finish(input int bound, output int fin);
    logic hit;
    hit = 1'b0;
    fin = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (finish) begin
        hit = 1'b1;
        fin = cyc;
      end
    end
    chk("finish_within_bound", hit, 1'b1);
  endtask

  initial begin
    int t0, fin;
    logic hit;

    repeat (3) @(negedge clk);
    chk_reset_outputs("por_outputs_zero");

    // Frame 1: latency 1, clean run.
    lat = 1;
    release_reset(t0);
    wait_finish(20000, fin);
    chk("t1_finish_latency_ok", 64'((fin - t0) <= N + 8), 64'd1);
    repeat (4) @(negedge clk);
    chk("t1_writes", 64'(wr_seen), 64'(N));
    chk("t1_dp_pixels", 64'(dp_seen), 64'(N));
    chk("t1_no_protocol_err", protocol_err, 1'b0);
    chk("t1_finish_held", finish, 1'b1);

    // Frame 2: latency 6 with a spurious return while idle.
    assert_reset();
    lat = 6;
    spur_req = 1'b1;
    release_reset(t0);
    repeat (3) @(negedge clk);
    chk("t4_protocol_err_set", protocol_err, 1'b1);
    wait_finish(40000, fin);
    chk("t2_min_frame_time", 64'((fin - t0) >= (N / 4) * 6), 64'd1);
    chk("t2_max_frame_time", 64'((fin - t0) <= (N / 4) * 7 + 64), 64'd1);
    repeat (4) @(negedge clk);
    chk("t2_writes", 64'(wr_seen), 64'(N));
    chk("t3_seen_return_at_max", 64'(t3_events > 0), 64'd1);
    chk("t4_protocol_err_sticky", protocol_err, 1'b1);

    // Frame 3: reset mid-frame, then a full frame.
    assert_reset();
    lat = 1;
    release_reset(t0);
    hit = 1'b0;
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(negedge clk);
      if (request && orig_addr == 14'd5000) hit = 1'b1;
    end
    chk("t5_reached_addr_5000", hit, 1'b1);
    assert_reset();
    release_reset(t0);
    wait_finish(20000, fin);
    repeat (4) @(negedge clk);
    chk("t5_writes_after_restart", 64'(wr_seen), 64'(N));
    chk("t5_no_protocol_err", protocol_err, 1'b0);

    // Extra result after finish must not be written.
    extra_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_write_after_finish", 64'(wr_seen), 64'(N));
    chk("t6_finish_held", finish, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
